// File: rtl/sensor_interval_timer.sv
// sensor_interval_timer
// Measures the time in ms between a train crossing track sensor 1 and track
// sensor 2. The result is presented on time_meas with a one-cycle meas_valid
// strobe. A measurement that runs too long is abandoned with a one-cycle
// timeout strobe. After either strobe both sensors are ignored for a lockout
// period.
module sensor_interval_timer #(
    parameter int TIME_W     = 19,
    parameter int TICK_DIV   = 50000,
    parameter int TIMEOUT_MS = 500000,
    parameter int LOCKOUT_MS = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sensor1,
    input  logic              sensor2,
    output logic [TIME_W-1:0] time_meas,
    output logic              meas_valid,
    output logic              timeout,
    output logic              busy
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST     = PRE_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] TIMEOUT_LAST = TIME_W'(TIMEOUT_MS - 1);
    localparam logic [TIME_W-1:0] LOCKOUT_LAST = TIME_W'(LOCKOUT_MS - 1);
    localparam logic [TIME_W-1:0] MEAS_MIN     = TIME_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TIMING  = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t             state;
    logic [PRE_W-1:0]   prescaler;
    logic [TIME_W-1:0]  ms_cnt;

    logic s1_meta, s1_sync, s1_prev;
    logic s2_meta, s2_sync, s2_prev;

    logic              rise1;
    logic              rise2;
    logic              tick;
    logic [TIME_W-1:0] ms_elapsed;
    logic [TIME_W-1:0] meas_value;

    // Two-flop synchronisers plus a previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_meta <= 1'b0;
            s1_sync <= 1'b0;
            s1_prev <= 1'b0;
            s2_meta <= 1'b0;
            s2_sync <= 1'b0;
            s2_prev <= 1'b0;
        end else begin
            s1_meta <= sensor1;
            s1_sync <= s1_meta;
            s1_prev <= s1_sync;
            s2_meta <= sensor2;
            s2_sync <= s2_meta;
            s2_prev <= s2_sync;
        end
    end

    // Edge detect, ms tick and the clamped measurement value. A tick landing
    // in the same cycle as rise2 is counted so the result is whole ms elapsed.
    always_comb begin
        rise1      = s1_sync & ~s1_prev;
        rise2      = s2_sync & ~s2_prev;
        tick       = (prescaler == PRE_LAST);
        ms_elapsed = tick ? (ms_cnt + 1'b1) : ms_cnt;
        meas_value = (ms_elapsed == '0) ? MEAS_MIN : ms_elapsed;
    end

    // Main FSM with prescaler, ms counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prescaler  <= '0;
            ms_cnt     <= '0;
            time_meas  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    prescaler <= '0;
                    if (rise1) begin
                        state  <= TIMING;
                        ms_cnt <= '0;
                        busy   <= 1'b1;
                    end
                end
                TIMING: begin
                    if (rise2) begin
                        time_meas  <= meas_value;
                        meas_valid <= 1'b1;
                        state      <= LOCKOUT;
                        ms_cnt     <= '0;
                        prescaler  <= '0;
                    end else if (tick) begin
                        prescaler <= '0;
                        if (ms_cnt == TIMEOUT_LAST) begin
                            timeout <= 1'b1;
                            state   <= LOCKOUT;
                            ms_cnt  <= '0;
                        end else begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (tick) begin
                        prescaler <= '0;
                        if (ms_cnt == LOCKOUT_LAST) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            ms_cnt <= '0;
                        end else begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    prescaler <= '0;
                    ms_cnt    <= '0;
                end
            endcase
        end
    end

endmodule
